// File: rtl/wb_cfg_master.sv
// Wishbone classic single-transfer master for the accelerator configuration port.
// Turns a command/response stream into one bus cycle at a time, with a timeout abort.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a command; bus idle
// S_BUS  | cyc/stb asserted, waiting for ack or timeout
// S_RESP | response presented, waiting for the consumer to take it
module wb_cfg_master #(
    parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_OFS_BW        = 16,
    parameter int          TIMEOUT_CYCLES     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [3:0]             cmd_sel_i,
    input  logic [ADDR_OFS_BW-1:0] cmd_addr_i,
    input  logic [31:0]            cmd_data_i,

    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_err_o,

    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [31:0]            wbm_dat_o,
    input  logic [31:0]            wbm_dat_i,
    input  logic                   wbm_ack_i,

    output logic                   busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [15:0] r_cnt;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_ack_hit;
    logic        w_timeout;
    logic        w_in_bus;
    logic [31:0] w_adr;

    // Byte address wraps modulo 2^32 by construction of the 32-bit sum.
    assign w_adr = WISHBONE_BASE_ADDR + 32'({cmd_addr_i, 2'b00});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_ack_hit = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept = 1'b1;
                    w_next   = S_BUS;
                end
            end
            S_BUS: begin
                // ack takes priority over a timeout landing on the same cycle
                if (wbm_ack_i) begin
                    w_ack_hit = 1'b1;
                    w_next    = S_RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_cnt      <= 16'h0;
            r_rsp_data <= 32'h0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_sel <= cmd_sel_i;
                r_adr <= w_adr;
                r_dat <= cmd_data_i;
                r_cnt <= 16'h0;
            end
            if (w_ack_hit) begin
                r_rsp_data <= r_we ? 32'h0 : wbm_dat_i;
                r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data <= 32'h0;
                r_rsp_err  <= 1'b1;
            end else if (r_state == S_BUS) begin
                r_cnt <= r_cnt + 16'h1;
            end
        end
    end

    assign w_in_bus    = (r_state == S_BUS);

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);

    assign wbm_cyc_o   = w_in_bus;
    assign wbm_stb_o   = w_in_bus;
    assign wbm_we_o    = w_in_bus & r_we;
    assign wbm_sel_o   = w_in_bus ? r_sel : 4'h0;
    assign wbm_adr_o   = w_in_bus ? r_adr : 32'h0;
    assign wbm_dat_o   = w_in_bus ? r_dat : 32'h0;

    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_data_o  = (r_state == S_RESP) ? r_rsp_data : 32'h0;
    assign rsp_err_o   = (r_state == S_RESP) & r_rsp_err;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Self-checking bench for wb_cfg_master: table vectors, random transfers against
// a transaction-level model, and hand sequences for reset, stray ack and throughput.
module tb_wb_cfg_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TO   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        cyc, stb, we_o, ack;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_cfg_master #(
        .WISHBONE_BASE_ADDR(BASE),
        .ADDR_OFS_BW       (16),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_sel_i  (cmd_sel),
        .cmd_addr_i (cmd_addr),
        .cmd_data_i (cmd_data),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we_o),
        .wbm_sel_o  (sel_o),
        .wbm_adr_o  (adr_o),
        .wbm_dat_o  (dat_o),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (ack),
        .busy_o     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: ack at wait state ws, abort after TO cycles.
    function automatic void model(input logic we, input logic [15:0] off, input int ws,
                                  input logic [31:0] rdata, output logic [31:0] adr,
                                  output int ncyc, output logic [31:0] data, output logic err);
        adr  = BASE + 32'(off) * 32'd4;
        err  = (ws >= TO);
        ncyc = err ? TO : ws + 1;
        data = (err || we) ? 32'h0 : rdata;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic xfer(input string name, input logic w, input logic [3:0] sel,
                        input logic [15:0] off, input logic [31:0] wdata, input int ws,
                        input logic [31:0] rdata, input int hold,
                        input logic [31:0] exp_adr, input int exp_cyc,
                        input logic [31:0] exp_data, input logic exp_err);
        int n;
        logic [31:0] bad_adr, bad_dat, bad_sel, bad_we;
        chk({name, " ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_sel   = sel;
        cmd_addr  = off;
        cmd_data  = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
        n = 0;
        bad_adr = 0; bad_dat = 0; bad_sel = 0; bad_we = 0;
        while (cyc && n < 50) begin
            n++;
            if (!stb)           bad_we  = bad_we | 32'h100;
            if (adr_o !== exp_adr) bad_adr = adr_o;
            if (dat_o !== wdata)   bad_dat = dat_o;
            if (sel_o !== sel)     bad_sel = 32'(sel_o) | 32'h10;
            if (we_o !== w)        bad_we  = bad_we | 32'h1;
            chk({name, " busy_in_bus"}, 32'(busy), 32'd1);
            ack   = (n - 1 == ws);
            dat_i = (n - 1 == ws) ? rdata : 32'hFFFF_0000 ^ 32'(n);
            @(negedge clk);
        end
        ack = 1'b0;
        chk({name, " bus_cycles"}, 32'(n), 32'(exp_cyc));
        chk({name, " adr_stable"}, bad_adr, 32'h0);
        chk({name, " dat_o_stable"}, bad_dat, 32'h0);
        chk({name, " sel_stable"}, bad_sel, 32'h0);
        chk({name, " we_stb_stable"}, bad_we, 32'h0);
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " rsp_data"}, rsp_data, exp_data);
        chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({name, " we_low_in_resp"}, 32'(we_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            ack   = (i == 2);
            dat_i = 32'hBAD0_BAD0;
            @(negedge clk);
            ack = 1'b0;
            chk({name, " hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, " hold_data"}, rsp_data, exp_data);
            chk({name, " hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({name, " hold_not_ready"}, 32'(cmd_ready), 32'd0);
            chk({name, " hold_cyc_low"}, 32'(cyc), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, " rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({name, " idle_again"}, 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  sel;
        logic [15:0] off;
        logic [31:0] wdata;
        int          ws;
        logic [31:0] rdata;
        int          hold;
        logic [31:0] exp_adr;
        int          exp_cyc;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int accepts;
        logic [31:0] m_adr, m_data;
        int          m_cyc;
        logic        m_err;
        logic        r_we;
        logic [15:0] r_off;
        int          r_ws;
        logic [31:0] r_rd, r_wd;

        vecs[0] = '{"wr_off3",   1'b1, 4'hF, 16'h0003, 32'hDEAD_BEEF, 0,  32'h0,         0, 32'h3000_000C, 1, 32'h0,         1'b0};
        vecs[1] = '{"rd_ws2",    1'b0, 4'hF, 16'h0010, 32'h0,         2,  32'h1234_5678, 0, 32'h3000_0040, 3, 32'h1234_5678, 1'b0};
        vecs[2] = '{"rd_tmo",    1'b0, 4'h3, 16'h0005, 32'h0,         99, 32'h5555_5555, 0, 32'h3000_0014, 4, 32'h0,         1'b1};
        vecs[3] = '{"wr_after",  1'b1, 4'h1, 16'h0007, 32'h0000_00AB, 1,  32'h0,         0, 32'h3000_001C, 2, 32'h0,         1'b0};
        vecs[4] = '{"rd_hold5",  1'b0, 4'hC, 16'h0020, 32'h0,         0,  32'hCAFE_F00D, 5, 32'h3000_0080, 1, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{"ack_at_to", 1'b0, 4'hF, 16'hFFFF, 32'h0,         3,  32'hA5A5_5A5A, 0, 32'h3003_FFFC, 4, 32'hA5A5_5A5A, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0; cmd_addr = 16'h0;
        cmd_data = 32'h0; rsp_ready = 1'b0; ack = 1'b0; dat_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", rsp_data, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst wbm_ctl", {28'h0, cyc, stb, we_o, 1'b0}, 32'h0);
        chk("rst wbm_sel", 32'(sel_o), 32'h0);
        chk("rst wbm_adr", adr_o, 32'h0);
        chk("rst wbm_dat", dat_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // stray ack while idle must not start anything
        ack = 1'b1; dat_i = 32'h1111_1111;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_stray_ack ready", 32'(cmd_ready), 32'd1);
        chk("idle_stray_ack cyc", 32'(cyc), 32'd0);
        chk("idle_stray_ack rsp", 32'(rsp_valid), 32'd0);

        foreach (vecs[i])
            xfer(vecs[i].name, vecs[i].we, vecs[i].sel, vecs[i].off, vecs[i].wdata, vecs[i].ws,
                 vecs[i].rdata, vecs[i].hold, vecs[i].exp_adr, vecs[i].exp_cyc,
                 vecs[i].exp_data, vecs[i].exp_err);

        for (int k = 0; k < 25; k++) begin
            r_we  = 1'($urandom);
            r_off = 16'($urandom);
            r_ws  = int'($urandom_range(0, 6));
            r_rd  = $urandom;
            r_wd  = $urandom;
            model(r_we, r_off, r_ws, r_rd, m_adr, m_cyc, m_data, m_err);
            xfer("rand", r_we, 4'($urandom), r_off, r_wd, r_ws, r_rd,
                 int'($urandom_range(0, 3)), m_adr, m_cyc, m_data, m_err);
        end

        // reset in the middle of BUS drops the transfer
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_addr = 16'h0042;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midrst in_bus", 32'(cyc), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst cyc", 32'(cyc), 32'd0);
        chk("midrst stb", 32'(stb), 32'd0);
        chk("midrst ready", 32'(cmd_ready), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        rsp_ready = 1'b1;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            ack = (i == 1); dat_i = 32'h7777_7777;
            @(negedge clk);
            if (rsp_valid) accepts++;
        end
        ack = 1'b0;
        chk("midrst no_rsp", 32'(accepts), 32'd0);

        // back-to-back zero-wait transfers: one accept every 3 cycles
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_data = 32'h0F0F_0F0F;
        ack = 1'b1;
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) accepts++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ack = 1'b0;
        chk("throughput accepts", 32'(accepts), 32'd4);
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        chk("final idle", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
